// File: rtl/sequence_game.sv
// ============================================================================
// sequence_game : memory-game sequencer (append, flash, check player input)
// Rev 1.0
// ============================================================================
`default_nettype none

module sequence_game #(
  parameter  int MAX_LEN    = 32,
  parameter  int ON_CYCLES  = 4,
  parameter  int GAP_CYCLES = 2,
  parameter  int TIMEOUT    = 50,
  localparam int LW         = $clog2(MAX_LEN + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [1:0]    ran_i,
  input  logic          start_i,
  input  logic          press_i,
  input  logic [1:0]    key_i,
  output logic [3:0]    led_o,
  output logic [LW-1:0] level_o,
  output logic          listening_o,
  output logic          win_o,
  output logic          fail_o
);

  localparam int IW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CMAX = (TIMEOUT > ON_CYCLES) ?
                        ((TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES) :
                        ((ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES);
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADD      = 3'd1,
    S_SHOW_ON  = 3'd2,
    S_SHOW_OFF = 3'd3,
    S_WAIT_IN  = 3'd4,
    S_WIN      = 3'd5,
    S_FAIL     = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      mem_q [MAX_LEN];
  logic            wr_en;
  logic [1:0]      show_sym;
  logic            last_elem;

  logic [3:0]      led_d;
  logic [LW-1:0]   level_d;

  assign last_elem = (LW'(idx_q) == len_q - LW'(1));

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    case (state_q)
      S_IDLE, S_WIN, S_FAIL: begin
        if (start_i) begin
          state_d = S_ADD;
          len_d   = '0;
        end
      end
      S_ADD: begin
        wr_en   = (len_q != LW'(MAX_LEN));
        if (len_q != LW'(MAX_LEN)) len_d = len_q + LW'(1);
        idx_d   = '0;
        cnt_d   = '0;
        state_d = S_SHOW_ON;
      end
      S_SHOW_ON: begin
        if (cnt_q == CW'(ON_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_SHOW_OFF;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SHOW_OFF: begin
        if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          cnt_d = '0;
          if (last_elem) begin
            idx_d   = '0;
            state_d = S_WAIT_IN;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = S_SHOW_ON;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_IN: begin
        // A press always wins over a timeout expiring in the same cycle.
        if (press_i) begin
          if (key_i == mem_q[idx_q]) begin
            cnt_d = '0;
            if (last_elem) begin
              idx_d   = '0;
              state_d = (len_q == LW'(MAX_LEN)) ? S_WIN : S_ADD;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            state_d = S_FAIL;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = S_FAIL;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The first flash of a fresh game shows the sample being written this cycle.
  assign show_sym = (wr_en && len_q == '0) ? ran_i : mem_q[idx_d];

  always_comb begin
    led_d   = 4'b0000;
    level_d = len_d;
    if (state_d == S_SHOW_ON) led_d = 4'b0001 << show_sym;
    else if (state_d == S_WIN) led_d = 4'b1111;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      led_o       <= '0;
      level_o     <= '0;
      listening_o <= 1'b0;
      win_o       <= 1'b0;
      fail_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      led_o       <= led_d;
      level_o     <= level_d;
      listening_o <= (state_d == S_WAIT_IN);
      win_o       <= (state_d == S_WIN);
      fail_o      <= (state_d == S_FAIL);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[len_q[IW-1:0]] <= ran_i;
  end

endmodule

`default_nettype wire

// File: tb/tb_sequence_game.sv
// ============================================================================
// tb_sequence_game : directed self-checking bench for sequence_game
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sequence_game;

  localparam int MAX_LEN    = 3;
  localparam int ON_CYCLES  = 4;
  localparam int GAP_CYCLES = 2;
  localparam int TIMEOUT    = 50;
  localparam int LW         = $clog2(MAX_LEN + 1);

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          start = 1'b0;
  logic          press = 1'b0;
  logic [1:0]    ran   = 2'd0;
  logic [1:0]    key   = 2'd0;
  logic [3:0]    led;
  logic [LW-1:0] level;
  logic          listening, win, fail;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sequence_game #(
    .MAX_LEN   (MAX_LEN),
    .ON_CYCLES (ON_CYCLES),
    .GAP_CYCLES(GAP_CYCLES),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .ran_i      (ran),
    .start_i    (start),
    .press_i    (press),
    .key_i      (key),
    .led_o      (led),
    .level_o    (level),
    .listening_o(listening),
    .win_o      (win),
    .fail_o     (fail)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_led"},   32'(led),       32'd0);
    check({tag, "_level"}, 32'(level),     32'd0);
    check({tag, "_listen"},32'(listening), 32'd0);
    check({tag, "_win"},   32'(win),       32'd0);
    check({tag, "_fail"},  32'(fail),      32'd0);
  endtask

  // Call while positioned in the cycle just before the flash starts.
  task automatic flash(input logic [1:0] sym, input string tag);
    logic [3:0] exp_led;
    exp_led = 4'b0001 << sym;
    for (int i = 0; i < ON_CYCLES; i++) begin
      step();
      check({tag, "_on"}, 32'(led), 32'(exp_led));
    end
    for (int i = 0; i < GAP_CYCLES; i++) begin
      step();
      check({tag, "_gap"}, 32'(led), 32'd0);
      check({tag, "_gap_listen"}, 32'(listening), 32'd0);
    end
  endtask

  task automatic press_key(input logic [1:0] k);
    press = 1'b1;
    key   = k;
    step();
    press = 1'b0;
  endtask

  task automatic start_game(input logic [1:0] r);
    ran   = r;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    // 1. reset, then reset asserted mid-show
    step();
    step();
    check_all_zero("por");
    rst = 1'b0;
    step();
    start_game(2'd2);
    step();
    check("pre_rst_led", 32'(led), 32'h4);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_all_zero("mid_show_rst");
    for (int i = 0; i < 8; i++) step();
    check_all_zero("idle_quiet");

    // 2. round 1
    start_game(2'd2);
    check("r1_add_level", 32'(level), 32'd0);
    flash(2'd2, "r1_f0");
    step();
    check("r1_listen", 32'(listening), 32'd1);
    check("r1_level",  32'(level),     32'd1);

    // 3. round 2
    ran = 2'd1;
    press_key(2'd2);
    check("r2_add_listen", 32'(listening), 32'd0);
    flash(2'd2, "r2_f0");
    flash(2'd1, "r2_f1");
    step();
    check("r2_listen", 32'(listening), 32'd1);
    check("r2_level",  32'(level),     32'd2);

    // 4. wrong key
    press_key(2'd2);
    check("wk_mid_listen", 32'(listening), 32'd1);
    press_key(2'd3);
    check("wk_fail",   32'(fail),      32'd1);
    check("wk_listen", 32'(listening), 32'd0);
    check("wk_level",  32'(level),     32'd2);
    check("wk_led",    32'(led),       32'd0);
    press_key(2'd1);
    step();
    check("wk_hold_fail",  32'(fail),  32'd1);
    check("wk_hold_level", 32'(level), 32'd2);

    // 5a. timeout with no press
    start_game(2'd0);
    check("to_fail_clr", 32'(fail), 32'd0);
    flash(2'd0, "to_f0");
    step();
    check("to_listen0", 32'(listening), 32'd1);
    for (int i = 1; i < TIMEOUT; i++) step();
    check("to_last_ok", 32'(fail), 32'd0);
    step();
    check("to_fail",    32'(fail),      32'd1);
    check("to_nolisten",32'(listening), 32'd0);

    // 5b. press on the final timeout cycle is accepted
    start_game(2'd3);
    flash(2'd3, "tp_f0");
    step();
    for (int i = 1; i < TIMEOUT; i++) step();
    check("tp_last_listen", 32'(listening), 32'd1);
    ran = 2'd1;
    press_key(2'd3);
    check("tp_no_fail", 32'(fail), 32'd0);
    flash(2'd3, "tp2_f0");
    flash(2'd1, "tp2_f1");
    step();
    check("tp2_listen", 32'(listening), 32'd1);
    check("tp2_level",  32'(level),     32'd2);

    // 6. win; Start during WAIT_IN is ignored
    start = 1'b1;
    press_key(2'd3);
    start = 1'b0;
    check("st_ign_listen", 32'(listening), 32'd1);
    ran = 2'd2;
    press_key(2'd1);
    flash(2'd3, "w3_f0");
    flash(2'd1, "w3_f1");
    flash(2'd2, "w3_f2");
    step();
    check("w3_level", 32'(level), 32'd3);
    press_key(2'd3);
    press_key(2'd1);
    press_key(2'd2);
    check("win",        32'(win),       32'd1);
    check("win_led",    32'(led),       32'hF);
    check("win_level",  32'(level),     32'd3);
    check("win_listen", 32'(listening), 32'd0);
    check("win_nofail", 32'(fail),      32'd0);
    press_key(2'd0);
    check("win_hold", 32'(win), 32'd1);
    start_game(2'd0);
    check("rs_win_clr", 32'(win), 32'd0);
    step();
    check("rs_level", 32'(level), 32'd1);
    check("rs_led",   32'(led),   32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
